instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries; legal values are powers of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 FB  input  Fetch_Bundle  fetch-stage output from Pkg; fields Address[31:0] and instr[31:0].
REQ-005 fb_valid  input  1  FB holds an instruction to enqueue this cycle.
REQ-006 fb_ready  output  1  queue accepts an entry this cycle.
REQ-007 flush  input  1  redirect from execute; discards all queued entries.
REQ-008 dq_valid  output  1  head entry is presented to decode.
REQ-009 dq_address  output  32  Address of the head entry.
REQ-010 dq_instr  output  32  instr of the head entry.
REQ-011 dq_ready  input  1  decode consumes the head entry this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 Push: a push SHALL occur when fb_valid && fb_ready && !flush; {FB.Address, FB.instr} is written at the write pointer.
REQ-014 Pop: a pop SHALL occur when dq_valid && dq_ready && !flush; the read pointer advances.
REQ-015 fb_ready SHALL be (count < DEPTH), combinational from registered state only, with no dependence on dq_ready.
REQ-016 dq_valid SHALL be (count != 0); dq_address and dq_instr SHALL show the head entry combinationally (first-word fall-through).
REQ-017 There SHALL be no bypass: an entry pushed in cycle N appears on dq_* no earlier than cycle N+1.
REQ-018 Latency on an empty queue SHALL be exactly 1 cycle from push to dq_valid.
REQ-019 Push and pop together (0 < count < DEPTH) SHALL leave count unchanged and advance both pointers.
REQ-020 Full (count == DEPTH): fb_ready SHALL be 0, so no push occurs; a pop in that cycle makes count DEPTH-1 and fb_ready 1 in the next cycle.
REQ-021 Empty (count == 0): dq_valid SHALL be 0 and dq_ready SHALL be ignored; dq_address/dq_instr are don't-care.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH or underflow below 0.
REQ-023 Order SHALL be strictly FIFO; entries SHALL never be duplicated, reordered or lost except by flush or reset.
REQ-024 Flush SHALL take priority over push and pop: next cycle count=0 and pointers=0, and any push or pop in the flush cycle is discarded.
REQ-025 While flush is high, fb_ready SHALL still reflect the pre-flush count; fetch treats the beat as dropped.
REQ-026 Asserting flush for several consecutive cycles SHALL keep the queue empty.

Reset
REQ-027 When reset is high at a rising edge: write pointer=0, read pointer=0, count=0.
REQ-028 The cycle after reset: dq_valid=0 and fb_ready=1.
REQ-029 Reset SHALL override flush, push and pop, including mid-stream with a full queue.
REQ-030 Storage array contents need not be reset and SHALL be unobservable while dq_valid=0.

Verification
REQ-031 Basic order: push A=0x00000000/0x00500093, then B=0x00000004/0x00100113 with dq_ready=0 -> count=2, dq shows A; dq_ready=1 for 2 cycles -> A then B, count=0.
REQ-032 Fill to full with DEPTH=4: 5 consecutive fb_valid beats, dq_ready=0 -> first 4 accepted, fb_ready=0 on the 5th beat, count=4, no overwrite.
REQ-033 Streaming: fb_valid=1 and dq_ready=1 for 20 cycles with incrementing Address -> count stays 1 after the first cycle and output addresses are sequential across pointer wrap.
REQ-034 Flush with simultaneous push and pop at count=3 -> next cycle count=0, dq_valid=0; the pushed beat never appears.
REQ-035 Reset mid-operation at count=4 -> next cycle count=0, dq_valid=0, fb_ready=1; a new push then appears 1 cycle later.
REQ-036 Scoreboard: random fb_valid, dq_ready and flush (flush about 5%) for 10k cycles -> output matches a reference FIFO model flushed identically, and count matches the model.

Source files
------------

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry first-word-fall-through
// FIFO of fetch bundles with a flush that empties it in one cycle.
package Pkg;
    typedef struct packed {
        logic [31:0] Address;
        logic [31:0] instr;
    } Fetch_Bundle;
endpackage

module instr_queue
    import Pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  Fetch_Bundle             FB,
    input  logic                    fb_valid,
    output logic                    fb_ready,
    input  logic                    flush,
    output logic                    dq_valid,
    output logic [31:0]             dq_address,
    output logic [31:0]             dq_instr,
    input  logic                    dq_ready,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    Fetch_Bundle      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_c, pop_c;

    // Handshake flags come from registered occupancy only, so fetch never sees dq_ready.
    assign fb_ready   = count_q < CNT_W'(DEPTH);
    assign dq_valid   = count_q != '0;
    assign dq_address = mem_q[rd_ptr_q].Address;
    assign dq_instr   = mem_q[rd_ptr_q].instr;
    assign count      = count_q;

    assign push_c = fb_valid && fb_ready && !flush;
    assign pop_c  = dq_valid && dq_ready && !flush;

    // Flush discards any same-cycle push or pop and rewinds both pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; it is only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem_q[wr_ptr_q] <= FB;
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus a randomized run
// scored against a queue-based reference FIFO.
module tb_instr_queue;
    import Pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    Fetch_Bundle fb;
    logic        fb_valid;
    logic        fb_ready;
    logic        flush;
    logic        dq_valid;
    logic [31:0] dq_address;
    logic [31:0] dq_instr;
    logic        dq_ready;
    logic [$clog2(DEPTH):0] count;

    int n_cmp;
    int n_err;

    Fetch_Bundle model_q[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .FB         (fb),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .flush      (flush),
        .dq_valid   (dq_valid),
        .dq_address (dq_address),
        .dq_instr   (dq_instr),
        .dq_ready   (dq_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference FIFO by the rules, then clock the DUT.
    task automatic tick();
        int  sz;
        bit  do_push;
        bit  do_pop;
        sz      = model_q.size();
        do_push = fb_valid && (sz < DEPTH) && !flush && !reset;
        do_pop  = dq_ready && (sz > 0) && !flush && !reset;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(fb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset    = 1'b0;
        flush    = 1'b0;
        fb_valid = 1'b0;
        dq_ready = 1'b0;
        fb       = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (dq_valid !== 1'b0) begin n_err++; $display("FAIL reset_dq_valid got %b want 0", dq_valid); end
        n_cmp++; if (fb_ready !== 1'b1) begin n_err++; $display("FAIL reset_fb_ready got %b want 1", fb_ready); end
    endtask

    task automatic test_basic_order();
        fb_valid = 1'b1;
        fb = '{Address: 32'h0000_0000, instr: 32'h0050_0093};
        #1;
        n_cmp++; if (dq_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass got %b want 0", dq_valid); end
        tick();
        n_cmp++; if (dq_valid !== 1'b1 || dq_address !== 32'h0) begin n_err++; $display("FAIL latency_one got v=%b a=%h want v=1 a=0", dq_valid, dq_address); end
        fb = '{Address: 32'h0000_0004, instr: 32'h0010_0113};
        tick();
        fb_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL order_count got %0d want 2", count); end
        n_cmp++; if (dq_address !== 32'h0 || dq_instr !== 32'h0050_0093) begin n_err++; $display("FAIL order_head_a got %h/%h want 00000000/00500093", dq_address, dq_instr); end
        dq_ready = 1'b1;
        tick();
        n_cmp++; if (dq_address !== 32'h4 || dq_instr !== 32'h0010_0113) begin n_err++; $display("FAIL order_head_b got %h/%h want 00000004/00100113", dq_address, dq_instr); end
        tick();
        n_cmp++; if (count !== 3'd0 || dq_valid !== 1'b0) begin n_err++; $display("FAIL order_drained got c=%0d v=%b want c=0 v=0", count, dq_valid); end
        idle_inputs();
    endtask

    task automatic test_fill_full();
        logic exp_rdy;
        dq_ready = 1'b0;
        fb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fb = '{Address: 32'h100 + 32'(4 * i), instr: 32'hA000_0000 + 32'(i)};
            #1;
            exp_rdy = (i < 4);
            n_cmp++; if (fb_ready !== exp_rdy) begin n_err++; $display("FAIL fill_ready beat%0d got %b want %b", i, fb_ready, exp_rdy); end
            tick();
        end
        fb_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
        // Pop at full while fetch still offers a beat: only the pop happens.
        fb_valid = 1'b1;
        fb = '{Address: 32'hDEAD_0000, instr: 32'hDEAD_BEEF};
        dq_ready = 1'b1;
        tick();
        fb_valid = 1'b0;
        dq_ready = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd3 || fb_ready !== 1'b1) begin n_err++; $display("FAIL full_pop got c=%0d r=%b want c=3 r=1", count, fb_ready); end
        dq_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_cmp++; if (dq_valid !== 1'b1 || dq_address !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL fill_drain%0d got v=%b a=%h want v=1 a=%h", i, dq_valid, dq_address, 32'h100 + 32'(4 * i)); end
            tick();
        end
        n_cmp++; if (dq_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty got %b want 0", dq_valid); end
        idle_inputs();
    endtask

    task automatic test_stream();
        fb_valid = 1'b1;
        dq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fb = '{Address: 32'h2000 + 32'(4 * i), instr: 32'h1300_0000 + 32'(i)};
            tick();
            n_cmp++; if (count !== 3'd1 || dq_address !== 32'h2000 + 32'(4 * i)) begin n_err++; $display("FAIL stream%0d got c=%0d a=%h want c=1 a=%h", i, count, dq_address, 32'h2000 + 32'(4 * i)); end
        end
        fb_valid = 1'b0;
        tick();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL stream_end got %0d want 0", count); end
        idle_inputs();
    endtask

    task automatic test_flush();
        fb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fb = '{Address: 32'h300 + 32'(4 * i), instr: 32'(i)};
            tick();
        end
        fb = '{Address: 32'hBAD0_0000, instr: 32'hBAD0_BAD0};
        dq_ready = 1'b1;
        flush = 1'b1;
        #1;
        n_cmp++; if (fb_ready !== 1'b1 || count !== 3'd3) begin n_err++; $display("FAIL flush_pre got r=%b c=%0d want r=1 c=3", fb_ready, count); end
        tick();
        n_cmp++; if (count !== 3'd0 || dq_valid !== 1'b0) begin n_err++; $display("FAIL flush_next got c=%0d v=%b want c=0 v=0", count, dq_valid); end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_held got %0d want 0", count); end
        idle_inputs();
        tick();
        n_cmp++; if (dq_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got %b want 0", dq_valid); end
    endtask

    task automatic test_reset_mid();
        fb_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fb = '{Address: 32'h400 + 32'(4 * i), instr: 32'(i)};
            tick();
        end
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL rmid_full got %0d want 4", count); end
        reset = 1'b1;
        flush = 1'b1;
        dq_ready = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (count !== 3'd0 || dq_valid !== 1'b0 || fb_ready !== 1'b1) begin n_err++; $display("FAIL rmid_after got c=%0d v=%b r=%b want 0/0/1", count, dq_valid, fb_ready); end
        fb_valid = 1'b1;
        fb = '{Address: 32'h5550_0000, instr: 32'h0000_0013};
        tick();
        fb_valid = 1'b0;
        #1;
        n_cmp++; if (dq_valid !== 1'b1 || dq_address !== 32'h5550_0000 || dq_instr !== 32'h13) begin n_err++; $display("FAIL rmid_push got v=%b %h/%h want 1 55500000/00000013", dq_valid, dq_address, dq_instr); end
        dq_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        int sz;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            fb_valid = 1'($urandom_range(0, 1));
            dq_ready = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 99) < 5);
            fb       = '{Address: $urandom, instr: $urandom};
            #1;
            sz = model_q.size();
            n_cmp++; if (count !== ($clog2(DEPTH) + 1)'(sz)) begin n_err++; $display("FAIL rnd_count cyc%0d got %0d want %0d", cyc, count, sz); end
            n_cmp++; if (dq_valid !== (sz != 0)) begin n_err++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, dq_valid, sz != 0); end
            n_cmp++; if (fb_ready !== (sz < DEPTH)) begin n_err++; $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, fb_ready, sz < DEPTH); end
            if (sz != 0) begin
                n_cmp++;
                if (dq_address !== model_q[0].Address || dq_instr !== model_q[0].instr) begin
                    n_err++;
                    $display("FAIL rnd_head cyc%0d got %h/%h want %h/%h", cyc, dq_address, dq_instr, model_q[0].Address, model_q[0].instr);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_basic_order();
        test_fill_full();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
